// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: datapath widths, PC-select codes and
// fetch FSM states.
package legv8_pkg;

   localparam int DATA_W  = 64;
   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      PS_HOLD = 2'b00,
      PS_INC  = 2'b01,
      PS_BR   = 2'b10,
      PS_CB   = 2'b11
   } ps_e;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC  = 2'b01,
      ST_ERROR = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection with word-alignment check.
// A hold selection never flags misalignment.
module pc_next_mux
   import legv8_pkg::*;
(
   input  logic [1:0]        ps_i,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] k_i,
   input  logic [DATA_W-1:0] a_i,
   output logic [DATA_W-1:0] next_pc_o,
   output logic [DATA_W-1:0] pc4_o,
   output logic              misaligned_o
);

   assign pc4_o = pc_i + 64'd4;

   always_comb begin
      next_pc_o = pc_i;
      case (ps_i)
         PS_INC:  next_pc_o = pc4_o;
         PS_BR:   next_pc_o = a_i;
         // k is a word offset; shifting out the top two bits matches mod-2^64 wrap
         PS_CB:   next_pc_o = pc_i + (k_i << 2);
         default: next_pc_o = pc_i;
      endcase
   end

   assign misaligned_o = (ps_i != PS_HOLD) && (next_pc_o[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches at PC, holds the instruction for the decoder,
// and updates PC from the control word's PC-select field.
module instr_fetch_unit
   import legv8_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          PS,
   input  logic [DATA_W-1:0]   k,
   input  logic [DATA_W-1:0]   A,
   input  logic                ps_valid,
   input  logic                stall,
   output logic                imem_req,
   output logic [DATA_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_ready,
   output logic [INSTR_W-1:0]  instr,
   output logic                instr_valid,
   output logic [DATA_W-1:0]   PC,
   output logic [DATA_W-1:0]   PC4,
   output logic                fault
);

   fetch_state_e        state_q;
   logic [DATA_W-1:0]   pc_q;
   logic [INSTR_W-1:0]  instr_q;
   logic                imem_req_q;
   logic                instr_valid_q;
   logic                fault_q;

   logic [DATA_W-1:0]   next_pc_d;
   logic                misaligned_d;

   pc_next_mux u_pc_next_mux (
      .ps_i         (PS),
      .pc_i         (pc_q),
      .k_i          (k),
      .a_i          (A),
      .next_pc_o    (next_pc_d),
      .pc4_o        (PC4),
      .misaligned_o (misaligned_d)
   );

   // imem_req stays low out of reset and rises on the first clock after release,
   // so a response to a request abandoned by reset is never captured.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (imem_req_q && imem_ready) begin
                  instr_q       <= imem_rdata;
                  imem_req_q    <= 1'b0;
                  instr_valid_q <= 1'b1;
                  state_q       <= ST_EXEC;
               end else begin
                  imem_req_q    <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (ps_valid && !stall && (PS != PS_HOLD)) begin
                  instr_valid_q <= 1'b0;
                  if (misaligned_d) begin
                     fault_q <= 1'b1;
                     state_q <= ST_ERROR;
                  end else begin
                     pc_q       <= next_pc_d;
                     imem_req_q <= 1'b1;
                     state_q    <= ST_FETCH;
                  end
               end
            end
            ST_ERROR: begin
               fault_q       <= 1'b1;
               imem_req_q    <= 1'b0;
               instr_valid_q <= 1'b0;
            end
            default: begin
               fault_q       <= 1'b1;
               imem_req_q    <= 1'b0;
               instr_valid_q <= 1'b0;
               state_q       <= ST_ERROR;
            end
         endcase
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign PC          = pc_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with hand-computed expected values.
module tb_instr_fetch_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  PS = 2'b00;
   logic [63:0] k = 64'h0;
   logic [63:0] A = 64'h0;
   logic        ps_valid = 1'b0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_ready = 1'b0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [63:0] PC;
   logic [63:0] PC4;
   logic        fault;

   int total = 0;
   int bad   = 0;

   instr_fetch_unit #(.RESET_PC(64'h0)) dut (
      .clock       (clock),
      .reset       (reset),
      .PS          (PS),
      .k           (k),
      .A           (A),
      .ps_valid    (ps_valid),
      .stall       (stall),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_ready  (imem_ready),
      .instr       (instr),
      .instr_valid (instr_valid),
      .PC          (PC),
      .PC4         (PC4),
      .fault       (fault)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fetch(input logic [31:0] data);
      imem_rdata = data;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
   endtask

   task automatic issue(input logic [1:0] ps, input logic [63:0] kv, input logic [63:0] av);
      PS = ps;
      k = kv;
      A = av;
      ps_valid = 1'b1;
      tick();
      ps_valid = 1'b0;
      PS = 2'b00;
   endtask

   initial begin
      #1 reset = 1'b1;
      #2;
      check("rst_pc", PC, 64'h0);
      check("rst_fault", {63'b0, fault}, 64'h0);
      check("rst_ivalid", {63'b0, instr_valid}, 64'h0);
      check("rst_req", {63'b0, imem_req}, 64'h0);
      tick();
      tick();
      check("rst_req_held", {63'b0, imem_req}, 64'h0);
      reset = 1'b0;
      tick();
      check("first_req", {63'b0, imem_req}, 64'h1);
      check("first_addr", imem_addr, 64'h0);

      // two wait cycles, then data
      tick();
      tick();
      check("wait_ivalid", {63'b0, instr_valid}, 64'h0);
      fetch(32'hB4AAAAA0);
      check("instr", {32'b0, instr}, 64'hB4AAAAA0);
      check("ivalid", {63'b0, instr_valid}, 64'h1);
      check("exec_req", {63'b0, imem_req}, 64'h0);

      // ready while no request outstanding is ignored
      imem_rdata = 32'hDEADBEEF;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check("ready_ignored", {32'b0, instr}, 64'hB4AAAAA0);

      issue(2'b01, 64'h0, 64'h0);
      check("inc_pc", PC, 64'h4);
      check("inc_req", {63'b0, imem_req}, 64'h1);
      check("inc_addr", imem_addr, 64'h4);
      check("inc_ivalid", {63'b0, instr_valid}, 64'h0);

      fetch(32'h11111111);
      issue(2'b10, 64'h0, 64'h100);
      check("br_100", PC, 64'h100);
      fetch(32'h22222222);
      issue(2'b11, -64'sd3, 64'h0);
      check("cb_neg3", PC, 64'hF4);
      fetch(32'h33333333);
      issue(2'b11, 64'd5, 64'h0);
      check("cb_pos5", PC, 64'h108);
      check("pc4_108", PC4, 64'h10C);

      fetch(32'h44444444);
      issue(2'b00, 64'h0, 64'h0);
      check("hold_pc", PC, 64'h108);
      check("hold_instr", {32'b0, instr}, 64'h44444444);
      check("hold_ivalid", {63'b0, instr_valid}, 64'h1);
      check("hold_req", {63'b0, imem_req}, 64'h0);
      stall = 1'b1;
      issue(2'b01, 64'h0, 64'h0);
      stall = 1'b0;
      check("stall_pc", PC, 64'h108);
      check("stall_ivalid", {63'b0, instr_valid}, 64'h1);
      check("stall_req", {63'b0, imem_req}, 64'h0);

      // wrap-around at top of address space
      issue(2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
      check("br_top", PC, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch(32'h55555555);
      check("pc4_wrap", PC4, 64'h0);
      issue(2'b01, 64'h0, 64'h0);
      check("wrap_pc", PC, 64'h0);
      check("wrap_fault", {63'b0, fault}, 64'h0);

      // misaligned branch target
      fetch(32'h66666666);
      issue(2'b10, 64'h0, 64'h2000);
      check("br_2000", PC, 64'h2000);
      fetch(32'h77777777);
      issue(2'b10, 64'h0, 64'h2002);
      check("mis_fault", {63'b0, fault}, 64'h1);
      check("mis_pc", PC, 64'h2000);
      check("mis_req", {63'b0, imem_req}, 64'h0);
      check("mis_ivalid", {63'b0, instr_valid}, 64'h0);
      imem_ready = 1'b1;
      tick();
      tick();
      imem_ready = 1'b0;
      issue(2'b01, 64'h0, 64'h0);
      check("err_sticky", {63'b0, fault}, 64'h1);
      check("err_req", {63'b0, imem_req}, 64'h0);
      check("err_pc", PC, 64'h2000);

      // reset out of error, then abandon a fetch with reset
      reset = 1'b1;
      #2;
      check("rst2_fault", {63'b0, fault}, 64'h0);
      check("rst2_pc", PC, 64'h0);
      tick();
      reset = 1'b0;
      tick();
      check("rst2_req", {63'b0, imem_req}, 64'h1);
      reset = 1'b1;
      #2;
      check("midrst_req", {63'b0, imem_req}, 64'h0);
      reset = 1'b0;
      imem_rdata = 32'hCAFEF00D;
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check("midrst_instr", {32'b0, instr}, 64'h0);
      check("midrst_ivalid", {63'b0, instr_valid}, 64'h0);
      check("midrst_req", {63'b0, imem_req}, 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clock, in, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, in, 1, asynchronous active-high reset.
REQ-004 SHALL have port PS, in, 2, PC select from control word: 00 hold, 01 PC+4, 10 register A, 11 PC+(k<<2).
REQ-005 SHALL have port k, in, 64, sign-extended branch offset in words from the control word.
REQ-006 SHALL have port A, in, 64, register-file read A value (BR target).
REQ-007 SHALL have port ps_valid, in, 1, control word valid this cycle.
REQ-008 SHALL have port stall, in, 1, blocks the PC update when high.
REQ-009 SHALL have port imem_req, out, 1, instruction memory read request.
REQ-010 SHALL have port imem_addr, out, 64, instruction memory address.
REQ-011 SHALL have port imem_rdata, in, 32, instruction memory read data.
REQ-012 SHALL have port imem_ready, in, 1, imem_rdata is valid this cycle.
REQ-013 SHALL have port instr, out, 32, registered instruction word for the control decoder.
REQ-014 SHALL have port instr_valid, out, 1, instr holds a valid instruction.
REQ-015 SHALL have port PC, out, 64, current PC; port PC4, out, 64, PC+4 for BL link.
REQ-016 SHALL have port fault, out, 1, misaligned next-PC detected.

Function
REQ-017 SHALL implement a three-state FSM: FETCH, EXEC, ERROR.
REQ-018 In FETCH: imem_req=1, imem_addr=PC, instr_valid=0; ps_valid and stall ignored.
REQ-019 In FETCH with imem_ready=1: instr<=imem_rdata, go to EXEC. Wait states of any length allowed.
REQ-020 imem_ready while imem_req=0 SHALL be ignored.
REQ-021 In EXEC: instr_valid=1, imem_req=0, instr stable.
REQ-022 In EXEC with ps_valid=1 and stall=0 and PS=00: PC unchanged, stay EXEC (multi-cycle instruction).
REQ-023 In EXEC with ps_valid=1 and stall=0 and PS!=00: PC<=next_pc, go to FETCH.
REQ-024 stall=1 in EXEC SHALL hold PC and state regardless of PS.
REQ-025 next_pc SHALL be PC+4 (01), A (10), PC+{k[61:0],2'b00} (11); all sums modulo 2^64, wrap-around silent.
REQ-026 PC4 SHALL equal PC+4 modulo 2^64, combinational.
REQ-027 If a PS!=00 update would produce next_pc[1:0]!=00: PC unchanged, go to ERROR.
REQ-028 In ERROR: fault=1, imem_req=0, instr_valid=0; remains until reset.
REQ-029 Latency: instruction available one cycle after the imem_ready cycle; fetch begins the cycle after a PC update.

Reset
REQ-030 Reset assertion SHALL immediately force PC=RESET_PC, instr=0, instr_valid=0, fault=0, state FETCH.
REQ-031 imem_req SHALL be 0 while reset is high, and 1 with imem_addr=RESET_PC from the first clock after release.
REQ-032 Reset mid-fetch SHALL abandon the request; a later imem_ready for it is not captured unless in FETCH.

Structure
REQ-033 PS encodings, FSM state encoding and width constants (64 data, 32 instruction) SHALL live in shared package legv8_pkg.
REQ-034 Next-PC computation and alignment check SHALL be a combinational sub-module pc_next_mux.

Verification
REQ-035 Reset then release -> PC=0, fault=0, instr_valid=0 during reset; imem_req=1, imem_addr=0 the first cycle after.
REQ-036 imem_ready after 2 wait cycles with rdata=32'hB4AAAAA0 -> instr=32'hB4AAAAA0, instr_valid=1; PS=01, ps_valid=1 -> PC=4, imem_req=1.
REQ-037 PC=64'h100, PS=11, k=-3 -> PC=64'hF4; PS=11, k=+5 from 64'hF4 -> PC=64'h108.
REQ-038 PS=10, A=64'h2000 -> PC=64'h2000; then PS=10, A=64'h2002 -> fault=1, PC stays 64'h2000, imem_req=0 until reset.
REQ-039 PS=00 with ps_valid=1 -> PC, instr unchanged, instr_valid=1, no request; stall=1 with PS=01 -> no change.
REQ-040 PC=64'hFFFF_FFFF_FFFF_FFFC, PS=01 -> PC=0, PC4 before update=0, no fault.
